// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer and the display stage:
// state encoding, BCD digit pair and digit helpers.
package countdown_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] ten;
        logic [3:0] unit;
    } bcd_t;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // Borrow from the tens digit when units underflow.
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.unit != 4'd0) begin
            r.unit = v.unit - 4'd1;
        end else begin
            r.unit = BCD_MAX;
            r.ten  = v.ten - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Board control and display-facing signals of the countdown timer.
// master = board/control side, slave = timer.
interface countdown_timer_if;

    logic       set;
    logic       start;
    logic       stop;
    logic [3:0] preset_ten;
    logic [3:0] preset_unit;
    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic       load;
    logic       running;
    logic       done;

    modport master (
        output set, start, stop, preset_ten, preset_unit,
        input  ten_count, unit_count, load, running, done
    );

    modport slave (
        input  set, start, stop, preset_ten, preset_unit,
        output ten_count, unit_count, load, running, done
    );

endinterface

// File: rtl/countdown_timer_prescaler.sv
// Clock prescaler: counts 0..CLK_DIV-1 while enabled and flags the
// last count as a tick; clear wins over enable and restarts at 0.
module tick_prescaler #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] count;

    assign tick = enable && (count == LAST);

    // Prescale counter; holds its value whenever not enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) count <= '0;
            else               count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer: control FSM, BCD decrement and the
// load strobe that tells the display stage to capture a new value.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    state_t state;
    bcd_t   cnt;
    bcd_t   cnt_dec;
    logic   load_q;
    logic   running_q;
    logic   done_q;
    logic   tick;
    logic   pre_clear;
    logic   pre_en;
    logic   nonzero;

    assign nonzero = (cnt != '0);
    assign cnt_dec = bcd_dec(cnt);

    // Prescaler runs only in RUN cycles that are not being paused or
    // preset, so a stop on the tick cycle leaves it parked at the top.
    assign pre_en    = (state == ST_RUN) && !bus.stop && !bus.set;
    assign pre_clear = bus.set || ((state == ST_IDLE) && bus.start && nonzero);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (pre_clear),
        .enable (pre_en),
        .tick   (tick)
    );

    assign bus.ten_count  = cnt.ten;
    assign bus.unit_count = cnt.unit;
    assign bus.load       = load_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;

    // Control FSM with registered count, load, running and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            load_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.set) begin
            state     <= ST_IDLE;
            cnt.ten   <= bcd_clamp(bus.preset_ten);
            cnt.unit  <= bcd_clamp(bus.preset_unit);
            load_q    <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            load_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start && nonzero) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state     <= ST_PAUSE;
                        running_q <= 1'b0;
                    end else if (tick) begin
                        cnt    <= cnt_dec;
                        load_q <= 1'b1;
                        if (cnt_dec == '0) begin
                            state     <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios plus random control
// traffic, every cycle compared against an integer-valued reference model.
module tb_countdown_timer;

    localparam int DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    int m_val;
    int m_mode;
    int m_phase;
    int m_load;
    int loads_seen;

    countdown_timer_if bus ();

    countdown_timer #(
        .CLK_DIV (DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int min9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    // Reference: value held as an integer 0..99, elapsed RUN cycles as phase.
    task automatic model_step();
        m_load = 0;
        if (reset) begin
            m_val = 0; m_mode = M_IDLE; m_phase = 0;
        end else if (bus.set) begin
            m_val   = min9(int'(bus.preset_ten)) * 10 + min9(int'(bus.preset_unit));
            m_mode  = M_IDLE;
            m_phase = 0;
            m_load  = 1;
        end else if (m_mode == M_IDLE) begin
            if (bus.start && m_val != 0) begin
                m_mode = M_RUN; m_phase = 0;
            end
        end else if (m_mode == M_RUN) begin
            if (bus.stop) begin
                m_mode = M_PAUSE;
            end else if (m_phase == DIV - 1) begin
                m_phase = 0;
                m_val   = m_val - 1;
                m_load  = 1;
                if (m_val == 0) m_mode = M_DONE;
            end else begin
                m_phase = m_phase + 1;
            end
        end else if (m_mode == M_PAUSE) begin
            if (bus.start && !bus.stop) m_mode = M_RUN;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("ten",     int'(bus.ten_count),  m_val / 10);
        chk("unit",    int'(bus.unit_count), m_val % 10);
        chk("load",    int'(bus.load),       m_load);
        chk("running", int'(bus.running),    int'(m_mode == M_RUN));
        chk("done",    int'(bus.done),       int'(m_mode == M_DONE));
        if (bus.load) loads_seen++;
    endtask

    task automatic drive(input bit s, input bit go, input bit st,
                         input int pt, input int pu);
        bus.set         = s;
        bus.start       = go;
        bus.stop        = st;
        bus.preset_ten  = 4'(pt);
        bus.preset_unit = 4'(pu);
    endtask

    task automatic idle_cycles(input int n);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic int shown();
        return int'(bus.ten_count) * 10 + int'(bus.unit_count);
    endfunction

    initial begin
        m_val = 0; m_mode = M_IDLE; m_phase = 0; m_load = 0;
        loads_seen = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cycle();
        cycle();
        reset = 1'b0;

        // 1: preset 12
        drive(1, 0, 0, 1, 2);
        cycle();
        chk("t1_val", shown(), 12);
        chk("t1_load", int'(bus.load), 1);
        idle_cycles(1);
        chk("t1_load_drop", int'(bus.load), 0);

        // 2: 12 -> 11 -> 10 -> 09
        drive(0, 1, 0, 0, 0);
        cycle();
        loads_seen = 0;
        idle_cycles(12);
        chk("t2_val", shown(), 9);
        chk("t2_loads", loads_seen, 3);

        // 3: 02 down to 00, then start held in DONE
        drive(1, 0, 0, 0, 2);
        cycle();
        drive(0, 1, 0, 0, 0);
        cycle();
        idle_cycles(8);
        chk("t3_val", shown(), 0);
        chk("t3_done", int'(bus.done), 1);
        loads_seen = 0;
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle();
        chk("t3_hold_loads", loads_seen, 0);
        chk("t3_hold_val", shown(), 0);

        // 4: stop on the tick cycle, resume after 10 cycles
        drive(1, 0, 0, 5, 5);
        cycle();
        drive(0, 1, 0, 0, 0);
        cycle();
        idle_cycles(3);
        drive(0, 0, 1, 0, 0);
        cycle();
        chk("t4_paused_val", shown(), 55);
        idle_cycles(10);
        drive(0, 1, 0, 0, 0);
        cycle();
        chk("t4_resume_val", shown(), 55);
        idle_cycles(1);
        chk("t4_tick_val", shown(), 54);
        chk("t4_tick_load", int'(bus.load), 1);

        // 5: clamp, set+start, start from 00
        drive(1, 0, 0, 15, 10);
        cycle();
        chk("t5_clamp", shown(), 99);
        drive(1, 1, 0, 4, 4);
        cycle();
        chk("t5_set_start_run", int'(bus.running), 0);
        drive(1, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 0, 0, 0);
        cycle();
        chk("t5_zero_start_run", int'(bus.running), 0);
        chk("t5_zero_start_load", int'(bus.load), 0);

        // 6: reset mid-RUN at 37
        drive(1, 0, 0, 3, 7);
        cycle();
        drive(0, 1, 0, 0, 0);
        cycle();
        idle_cycles(2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t6_val", shown(), 0);
        chk("t6_load", int'(bus.load), 0);

        // Random control traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)));
            cycle();
        end
        reset = 1'b0;
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
